// File: rtl/lenet_layer_sequencer.sv
// Layer command sequencer for a small LeNet-style accelerator: walks conv1, conv2,
// conv3 and the fc layer, issuing one (layer, oc, ic) command at a time under a watchdog.
module lenet_layer_sequencer #(
    parameter int C1_OC   = 2,
    parameter int C2_OC   = 2,
    parameter int C2_IC   = 2,
    parameter int C3_OC   = 10,
    parameter int C3_IC   = 2,
    parameter int FC_ROWS = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd_layer,
    output logic [3:0]  cmd_oc,
    output logic        cmd_ic,
    output logic        cmd_acc_clear,
    output logic        cmd_last_ic,
    input  logic        op_done,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  op_count,
    output logic [31:0] cycle_count
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      layer;
    logic [3:0]      oc;
    logic            ic;
    logic [WD_W-1:0] wd;

    logic start_run;
    logic complete;
    logic wd_tick;
    logic timeout_hit;
    logic ic_end;
    logic oc_end;
    logic last_cmd;

    // Per-layer index limits; conv1 and fc have a single input channel.
    function automatic logic [3:0] oc_last(input logic [1:0] l);
        case (l)
            2'd0:    oc_last = 4'(C1_OC - 1);
            2'd1:    oc_last = 4'(C2_OC - 1);
            2'd2:    oc_last = 4'(C3_OC - 1);
            default: oc_last = 4'(FC_ROWS - 1);
        endcase
    endfunction

    function automatic logic ic_last(input logic [1:0] l);
        case (l)
            2'd1:    ic_last = 1'(C2_IC - 1);
            2'd2:    ic_last = 1'(C3_IC - 1);
            default: ic_last = 1'b0;
        endcase
    endfunction

    assign ic_end   = (ic == ic_last(layer));
    assign oc_end   = (oc == oc_last(layer));
    assign last_cmd = (layer == 2'd3) && oc_end && ic_end;

    // NOTE: state and counters use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the always blocks are evaluated in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        start_run   = 1'b0;
        complete    = 1'b0;
        wd_tick     = 1'b0;
        timeout_hit = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_ISSUE;
                        start_run = 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (cmd_ready) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // op_done is tested first so it wins over a same-edge timeout.
                    if (op_done) begin
                        complete  = 1'b1;
                        state_nxt = last_cmd ? S_DONE : S_ISSUE;
                    end else if (wd == WD_LAST) begin
                        timeout_hit = 1'b1;
                        state_nxt   = S_ERR;
                    end else begin
                        wd_tick = 1'b1;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                S_ERR:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer       <= '0;
            oc          <= '0;
            ic          <= 1'b0;
            wd          <= '0;
            err         <= 1'b0;
            op_count    <= '0;
            cycle_count <= '0;
        end else begin
            wd <= wd_tick ? wd + 1'b1 : '0;

            if (start_run) begin
                layer       <= '0;
                oc          <= '0;
                ic          <= 1'b0;
                err         <= 1'b0;
                op_count    <= '0;
                cycle_count <= '0;
            end else begin
                if (busy && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
                if (timeout_hit) err <= 1'b1;
                if (complete) begin
                    op_count <= op_count + 1'b1;
                    // ic is the fastest index, then oc, then layer.
                    if (!ic_end) begin
                        ic <= 1'b1;
                    end else begin
                        ic <= 1'b0;
                        if (!oc_end) begin
                            oc <= oc + 1'b1;
                        end else begin
                            oc    <= '0;
                            layer <= layer + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign cmd_valid     = (state == S_ISSUE);
    assign busy          = (state == S_ISSUE) || (state == S_WAIT);
    assign done          = (state == S_DONE);
    assign cmd_layer     = layer;
    assign cmd_oc        = oc;
    assign cmd_ic        = ic;
    // Flags are qualified by cmd_valid so they read 0 while idle or in reset.
    assign cmd_acc_clear = cmd_valid && !ic;
    assign cmd_last_ic   = cmd_valid && ic_end;

endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Scoreboard bench for lenet_layer_sequencer: a responder models the datapath,
// a monitor compares every presented command against a list built from the layer shapes.
module tb_lenet_layer_sequencer;

    localparam int TIMEOUT = 4096;
    localparam int N_CMD   = 36;

    typedef struct packed {
        logic [1:0] layer;
        logic [3:0] oc;
        logic       ic;
        logic       clr;
        logic       last;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        tb_abort;
    logic        resp_abort;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_layer;
    logic [3:0]  cmd_oc;
    logic        cmd_ic;
    logic        cmd_acc_clear;
    logic        cmd_last_ic;
    logic        op_done;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  op_count;
    logic [31:0] cycle_count;

    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    int   cmd_idx = 0;
    int   hold_idx = -1;
    int   abort_idx = -1;
    int   rdy_dly [N_CMD];
    int   done_dly[N_CMD];
    bit   spur_od [N_CMD];
    cmd_t model   [N_CMD];
    cmd_t exp_q[$];

    assign abort = tb_abort | resp_abort;

    always #5 clk = ~clk;

    lenet_layer_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_layer    (cmd_layer),
        .cmd_oc       (cmd_oc),
        .cmd_ic       (cmd_ic),
        .cmd_acc_clear(cmd_acc_clear),
        .cmd_last_ic  (cmd_last_ic),
        .op_done      (op_done),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .op_count     (op_count),
        .cycle_count  (cycle_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected command order: layer outer, oc middle, ic inner.
    task automatic build_model();
        int oc_n[4];
        int ic_n[4];
        int n;
        oc_n = '{2, 2, 10, 10};
        ic_n = '{1, 2, 2, 1};
        n = 0;
        for (int l = 0; l < 4; l++)
            for (int o = 0; o < oc_n[l]; o++)
                for (int i = 0; i < ic_n[l]; i++) begin
                    model[n] = '{layer: 2'(l), oc: 4'(o), ic: 1'(i),
                                 clr: (i == 0), last: (i == ic_n[l] - 1)};
                    n++;
                end
    endtask

    task automatic clear_delays();
        for (int k = 0; k < N_CMD; k++) begin
            rdy_dly[k]  = 0;
            done_dly[k] = 0;
            spur_od[k]  = 1'b0;
        end
    endtask

    // Datapath model: ready after rdy_dly ISSUE stall cycles, op_done after done_dly extra WAIT cycles.
    initial begin : responder
        int k;
        cmd_ready  = 1'b0;
        op_done    = 1'b0;
        resp_abort = 1'b0;
        @(negedge clk);
        forever begin
            if (cmd_valid && rst_n && cmd_idx < N_CMD) begin
                k = cmd_idx;
                op_done = spur_od[k];
                repeat (rdy_dly[k]) @(negedge clk);
                op_done   = 1'b0;
                cmd_ready = 1'b1;
                @(negedge clk);
                cmd_ready = 1'b0;
                cmd_idx++;
                if (k == abort_idx) begin
                    resp_abort = 1'b1;
                    @(negedge clk);
                    resp_abort = 1'b0;
                end else if (k != hold_idx) begin
                    repeat (done_dly[k]) @(negedge clk);
                    op_done = 1'b1;
                    @(negedge clk);
                    op_done = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    initial begin : monitor
        cmd_t got;
        forever begin
            @(negedge clk);
            #1;
            if (done) done_seen++;
            if (cmd_valid) begin
                got = {cmd_layer, cmd_oc, cmd_ic, cmd_acc_clear, cmd_last_ic};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected actual=%0h required=none", got);
                end else begin
                    check("cmd_fields", got, exp_q[0]);
                    if (cmd_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One run from start to end; expectations derived from the delay tables.
    task automatic do_run(input string tag, input int hold_i, input int abort_i);
        int  n_issue;
        int  n_done;
        int  exp_busy;
        int  end_w;
        int  cyc;
        bit  normal;
        hold_idx  = hold_i;
        abort_idx = abort_i;
        cmd_idx   = 0;
        done_seen = 0;
        normal    = (hold_i < 0) && (abort_i < 0);
        n_issue   = (hold_i >= 0) ? hold_i + 1 : (abort_i >= 0) ? abort_i + 1 : N_CMD;
        n_done    = normal ? N_CMD : n_issue - 1;
        exp_busy  = 0;
        for (int k = 0; k < n_issue; k++) begin
            exp_q.push_back(model[k]);
            if (k == hold_i)       end_w = TIMEOUT;
            else if (k == abort_i) end_w = 1;
            else                   end_w = 1 + done_dly[k];
            exp_busy += 1 + rdy_dly[k] + end_w;
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        check({tag, "_err_cleared"}, err, 0);
        cyc = 1;
        while (busy && cyc < 20000) begin
            @(negedge clk);
            #1;
            cyc++;
            start = (cyc == 10) && busy;
        end
        start = 1'b0;
        check({tag, "_end_cycle"}, cyc, exp_busy + 1);
        check({tag, "_done_pulse"}, done, normal);
        check({tag, "_valid_end"}, cmd_valid, 0);

        repeat (3) @(negedge clk);
        #1;
        check({tag, "_op_count"}, op_count, n_done);
        check({tag, "_cycle_count"}, cycle_count, exp_busy);
        check({tag, "_done_count"}, done_seen, normal ? 1 : 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_err"}, err, (hold_i >= 0));
        exp_q.delete();
    endtask

    initial begin : stimulus
        build_model();
        clear_delays();
        rst_n    = 1'b0;
        start    = 1'b0;
        tb_abort = 1'b0;

        #12;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_op_count", op_count, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_cmd_fields", {cmd_layer, cmd_oc, cmd_ic, cmd_acc_clear, cmd_last_ic}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("idle_no_start", busy, 0);

        do_run("ideal", -1, -1);

        // conv2 oc=1 ic=0 is command 4; stray op_done pulses during the stall.
        rdy_dly[4] = 5;
        spur_od[4] = 1'b1;
        do_run("backpressure", -1, -1);
        clear_delays();

        // op_done on the final permitted WAIT cycle must beat the timeout.
        done_dly[5] = TIMEOUT - 1;
        do_run("wd_edge", -1, -1);
        clear_delays();

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N_CMD; k++) begin
                rdy_dly[k]  = $urandom_range(0, 3);
                done_dly[k] = $urandom_range(0, 3);
                spur_od[k]  = 1'($urandom_range(0, 1));
            end
            do_run("random", -1, -1);
        end
        clear_delays();

        // conv3 oc=4 ic=0 is command 14.
        do_run("timeout", 14, -1);

        @(negedge clk);
        tb_abort = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        #1;
        tb_abort = 1'b0;
        start    = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_err_held", err, 1);
        repeat (2) @(negedge clk);
        #1;
        check("abort_start_still_idle", busy, 0);

        // fc row 3 is command 29.
        do_run("abort", -1, 29);

        // Reset asserted between edges while command 1 is stalled in ISSUE.
        rdy_dly[1] = 6;
        hold_idx   = -1;
        abort_idx  = -1;
        cmd_idx    = 0;
        exp_q.push_back(model[0]);
        exp_q.push_back(model[1]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cmd_valid", cmd_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_op_count", op_count, 0);
        check("arst_cycle_count", cycle_count, 0);
        check("arst_cmd_fields", {cmd_layer, cmd_oc, cmd_ic, cmd_acc_clear, cmd_last_ic}, 0);
        check("arst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("post_rst_idle", busy, 0);
        check("post_rst_op_count", op_count, 0);
        exp_q.delete();
        clear_delays();

        do_run("post_rst", -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
